// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
package booth_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SIGN_UU = 2'b00;
  localparam logic [1:0] SIGN_SU = 2'b01;
  localparam logic [1:0] SIGN_SS = 2'b11;

  localparam int unsigned DEF_TIMEOUT = 63;

endpackage

// File: rtl/booth_mult8_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_mult8_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit Booth multiplier among NREQ clients.
// Optional WAIT watchdog enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult8_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_multiplicand,
  input  logic [NREQ*8-1:0] req_multiplier,
  input  logic [NREQ*2-1:0] req_sign_mode,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_product,
  output logic              rsp_error,
  output logic              core_start,
  output logic [7:0]        core_multiplicand,
  output logic [7:0]        core_multiplier,
  output logic [1:0]        core_sign_mode,
  input  logic [15:0]       core_product,
  input  logic              core_done,
  output logic              busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q;
  logic [7:0]        op_a_q, op_b_q;
  logic [1:0]        op_sm_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [15:0]       rsp_product_q;
  logic              rsp_error_q;
  logic              core_start_q;
  logic              busy_q;

  logic [NREQ-1:0]   grant_c;
  logic [IDW-1:0]    win_id_c;
  logic              any_c;
  logic [7:0]        sel_a_c, sel_b_c;
  logic [1:0]        sel_sm_c;

  rr_pick #(.N(NREQ), .IDW(IDW)) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_c),
    .id_o    (win_id_c),
    .any_o   (any_c)
  );

  // Operand mux for the winning slot (grant is one-hot).
  always_comb begin
    sel_a_c  = '0;
    sel_b_c  = '0;
    sel_sm_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_a_c  = req_multiplicand[i*8 +: 8];
        sel_b_c  = req_multiplier[i*8 +: 8];
        sel_sm_c = req_sign_mode[i*2 +: 2];
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] wait_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                  wait_cnt_q <= '0;
    else if (state_q != ST_WAIT) wait_cnt_q <= '0;
    else                         wait_cnt_q <= wait_cnt_q + CNTW'(1);
  end
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE:  if (any_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done) state_d = ST_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNTW'(TIMEOUT)) state_d = ST_RESP;
`endif
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_sm_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_error_q   <= 1'b0;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      core_start_q <= (state_d == ST_ISSUE);
      busy_q       <= (state_d != ST_IDLE);
      rsp_valid_q  <= '0;
      if (state_q == ST_IDLE && any_c) begin
        id_q    <= win_id_c;
        op_a_q  <= sel_a_c;
        op_b_q  <= sel_b_c;
        op_sm_q <= sel_sm_c;
      end
      if (state_q == ST_WAIT && state_d == ST_RESP) begin
        rsp_valid_q <= NREQ'(1) << id_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
        rsp_product_q <= core_done ? core_product : '0;
        rsp_error_q   <= !core_done;
`else
        rsp_product_q <= core_product;
        rsp_error_q   <= 1'b0;
`endif
      end
    end
  end

  // Grant is visible in the same IDLE cycle the request is seen.
  assign req_ready         = (rst_n && state_q == ST_IDLE) ? grant_c : '0;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_product       = rsp_product_q;
  assign rsp_error         = rsp_error_q;
  assign core_start        = core_start_q;
  assign core_multiplicand = op_a_q;
  assign core_multiplier   = op_b_q;
  assign core_sign_mode    = op_sm_q;
  assign busy              = busy_q;

endmodule

// File: doc/booth_mult8_arbiter.md
# booth_mult8_arbiter

Round-robin arbiter and sequencer sharing one `booth_mult8_core`-class 8-bit Booth multiplier among `NREQ` requesters. It sits between the client blocks and the multiplier's start/operand/done interface. It accepts one request at a time, holds the operands stable, pulses the core's start, waits for done, and routes the product back to the granted requester.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 63: maximum WAIT cycles before abort. Used only with `BOOTH_ARB_TIMEOUT_EN`.
- `IDW`: localparam equal to `$clog2(NREQ)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NREQ: per-requester request.
- `req_multiplicand` in NREQ*8: packed operand A; slot i is bits [8i+7:8i].
- `req_multiplier` in NREQ*8: packed operand B.
- `req_sign_mode` in NREQ*2: packed sign mode.
- `req_ready` out NREQ: one-hot accept pulse.
- `rsp_valid` out NREQ: one-hot response pulse.
- `rsp_product` out 16: result, shared by all requesters.
- `rsp_error` out 1: timeout flag, qualified by `rsp_valid`.
- `core_start` out 1: start pulse to the multiplier.
- `core_multiplicand`, `core_multiplier` out 8 each: operands to the multiplier.
- `core_sign_mode` out 2: sign mode to the multiplier.
- `core_product` in 16: product from the multiplier.
- `core_done` in 1: done pulse from the multiplier.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is set, pick the winner by round-robin starting at `rr_ptr`.
  - Assert `req_ready[win]` for this cycle only.
  - Latch that requester's operands, sign mode and id into the operand register.
  - Go to ISSUE.
- **ISSUE:** `core_start`=1 for exactly one cycle. Go to WAIT.
- **WAIT:**
  - On `core_done`, capture `core_product` and go to RESP.
  - `core_done` seen in any other state is ignored.
- **RESP:**
  - `rsp_valid[id]`=1 for one cycle; `rsp_product` holds the captured value.
  - Set `rr_ptr` = (id+1) mod NREQ.
  - Go to IDLE.
- `core_*` operand outputs come from the operand register and stay stable from ISSUE through RESP.
- A requester holds `req_valid` and its operands stable until it sees `req_ready`. Deasserting before `req_ready` is legal; the request is then never granted.
- `rsp_product` and `rsp_error` hold their values until the next RESP.
- The arbiter does no arithmetic; width and sign handling belong to the core.

Reset (`rst_n`=0 at a clock edge):
- State returns to IDLE and `rr_ptr`=0.
- All outputs go to 0: `req_ready`, `rsp_valid`, `core_start`, `core_*` operands, `rsp_product`, `rsp_error`, `busy`.
- Reset mid-transaction drops the transaction with no response. The core must be reset by the same `rst_n`.

## Timing
- A request seen in IDLE at cycle 0 gets `req_ready` at cycle 0 and `core_start` at cycle 1.
- If `core_done` arrives at cycle 1+L, `rsp_valid` is at cycle 2+L and the arbiter is back in IDLE at cycle 3+L.
- Back-to-back: the next grant can come at cycle 3+L. No overlap; there is only ever one transaction in flight.
- `core_done` in the same cycle as `core_start` is not legal. The arbiter only samples `core_done` from WAIT.
- Simultaneous requests: grant goes to the first set bit at or after `rr_ptr`, with wrap-around (NREQ-1 → 0).
- A requester re-requesting immediately after its own RESP loses to any other pending requester.

## Configuration
- **`BOOTH_ARB_TIMEOUT_EN` defined:**
  - A WAIT cycle counter clears on entry to WAIT.
  - When the count reaches `TIMEOUT` without `core_done`, go to RESP with `rsp_error`=1 and `rsp_product`=0.
  - A `core_done` arriving after that is ignored.
- **Undefined:** no counter. WAIT waits indefinitely and `rsp_error` is tied to 0.

## Structure
- Shared package `booth_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - `SIGN_UU`/`SIGN_SU`/`SIGN_SS` sign-mode constants;
  - the default `TIMEOUT`.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and an encoded id.

## Test plan
- **Single request:** req 2 with A=-3, B=7, sign_mode SS; model core L=9 returning -21 (16'hFFEB). Expect `req_ready[2]` at c0, `core_start` at c1, `rsp_valid[2]` at c11 with product FFEB, and `busy` low at c12.
- **Round-robin:** all 4 requesters held high. Expect grant order 0,1,2,3,0, with `rr_ptr` wrapping after 3.
- **Mid-transaction requests:** req 1 arrives while WAIT serves req 3. Expect no `req_ready` until IDLE, then `req_ready[1]`. Operands on `core_*` stay unchanged throughout WAIT.
- **Reset in WAIT:** assert `rst_n`=0 for one cycle during WAIT. Expect all outputs 0, no `rsp_valid`, and the next grant going to req 0.
- **Stray done:** pulse `core_done` in IDLE. Expect no state change and no `rsp_valid`.
- **Timeout (`BOOTH_ARB_TIMEOUT_EN`, `TIMEOUT`=15):** model core never asserts done. Expect `rsp_valid` with `rsp_error`=1 and `rsp_product`=0 at WAIT entry+16, and a late `core_done` ignored.
